uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio_pkg.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 71 +++++++
 rtl/uart_mmio.sv | 136 +++++++++++++
 tb/tb_uart_mmio.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// ============================================================================
// Module      : uart_mmio_pkg
// Description : Register offsets, STATUS bit indices and address decode for uart_mmio.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_mmio_pkg;

  localparam logic [31:0] OFF_STATUS     = 32'h0000_0000;
  localparam logic [31:0] OFF_RXDATA     = 32'h0000_0004;
  localparam logic [31:0] OFF_TXDATA     = 32'h0000_0008;
  localparam logic [31:0] OFF_CYCLES     = 32'h0000_0010;
  localparam logic [31:0] OFF_CYCLES_RST = 32'h0000_0018;

  localparam int STAT_TX_EMPTY    = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_RX_OVF      = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STATUS,
    SEL_RXDATA,
    SEL_TXDATA,
    SEL_CYCLES,
    SEL_CYCLES_RST
  } reg_sel_e;

  // Exact-match decode: unaligned or out-of-window addresses select nothing.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    case (off)
      OFF_STATUS:     return SEL_STATUS;
      OFF_RXDATA:     return SEL_RXDATA;
      OFF_TXDATA:     return SEL_TXDATA;
      OFF_CYCLES:     return SEL_CYCLES;
      OFF_CYCLES_RST: return SEL_CYCLES_RST;
      default:        return SEL_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Byte FIFO with first-word-fall-through head and wrapping pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio.sv
// ============================================================================
// Module      : uart_mmio
// Description : Memory-mapped UART front end: STATUS/RXDATA/TXDATA registers,
//               RX FIFO and single-byte TX buffer. UART_MMIO_CYCLE_COUNTER_EN
//               adds a 32-bit cycle counter at +0x10 (clear via write to +0x18).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  reg_sel_e                sel;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             status_w;
  logic [31:0]             cyc_val;
  logic                    tx_full_q, tx_full_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    ovf_q, ovf_d;
  logic                    fifo_full, fifo_empty;
  logic [7:0]              fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_push, fifo_pop;
  logic                    tx_wr;
  logic                    unused_bits;

  assign sel = decode_addr(addr, BASE);

  assign fifo_push = rx_valid & ~fifo_full;
  assign fifo_pop  = re & (sel == SEL_RXDATA) & ~fifo_empty;
  assign rx_ready  = ~fifo_full;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (rx_data),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign unused_bits = ^{wdata[31:8], fifo_count};

  always_comb begin
    status_w                   = '0;
    status_w[STAT_TX_EMPTY]    = ~tx_full_q;
    status_w[STAT_RX_NONEMPTY] = ~fifo_empty;
    status_w[STAT_RX_OVF]      = ovf_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      case (sel)
        SEL_STATUS: rdata_d = status_w;
        SEL_RXDATA: rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_head};
        SEL_CYCLES: rdata_d = cyc_val;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  // A new overflow on the same edge as a STATUS read keeps the flag set.
  assign ovf_d = (rx_valid & fifo_full) | (ovf_q & ~(re & (sel == SEL_STATUS)));

  // Writes only land in an empty buffer, so they never race a handshake.
  assign tx_wr = we & (sel == SEL_TXDATA) & ~tx_full_q;

  always_comb begin
    tx_full_d = tx_full_q;
    tx_data_d = tx_data_q;
    if (tx_wr) begin
      tx_full_d = 1'b1;
      tx_data_d = wdata[7:0];
    end else if (tx_full_q && tx_ready) begin
      tx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      tx_full_q <= 1'b0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      tx_full_q <= tx_full_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rdata    = rdata_q;
  assign tx_valid = tx_full_q;
  assign tx_data  = tx_data_q;

`ifdef UART_MMIO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  assign cyc_d = (we && (sel == SEL_CYCLES_RST)) ? 32'd0 : cyc_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio.sv
// ============================================================================
// Module      : tb_uart_mmio
// Description : Directed and random stimulus for uart_mmio against a queue-based
//               reference model of the register window.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_mmio;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  always #5 clk = ~clk;

  uart_mmio #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, TX is a flag plus byte.
  logic [7:0]  m_q[$];
  bit          m_ovf;
  bit          m_txf;
  logic [7:0]  m_txd;
  logic [31:0] m_rdata;
  logic [31:0] m_cyc;
  bit          m_push;
  bit          m_pop;

  function automatic void model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_txf   = 1'b0;
    m_txd   = '0;
    m_rdata = '0;
    m_cyc   = '0;
    m_push  = 1'b0;
    m_pop   = 1'b0;
  endfunction

  function automatic void model_step();
    logic [31:0] off;
    bit full;
    bit empty;
    off   = addr - BASE;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    m_pop  = re && (off == 32'h4) && !empty;
    m_push = rx_valid && !full;
    if (re) begin
      case (off)
        32'h0:   m_rdata = {29'd0, m_ovf, !empty, !m_txf};
        32'h4:   m_rdata = empty ? 32'd0 : {24'd0, m_q[0]};
`ifdef UART_MMIO_CYCLE_COUNTER_EN
        32'h10:  m_rdata = m_cyc;
`endif
        default: m_rdata = 32'd0;
      endcase
    end
    m_ovf = (rx_valid && full) || (m_ovf && !(re && off == 32'h0));
    if (m_pop)  void'(m_q.pop_front());
    if (m_push) m_q.push_back(rx_data);
    if (m_txf) begin
      if (tx_ready) m_txf = 1'b0;
    end else if (we && off == 32'h8) begin
      m_txf = 1'b1;
      m_txd = wdata[7:0];
    end
    m_cyc = (we && off == 32'h18) ? 32'd0 : m_cyc + 32'd1;
  endfunction

  task automatic compare_all();
    check_eq("rdata",    rdata,          m_rdata);
    check_eq("tx_valid", 32'(tx_valid),  32'(m_txf));
    check_eq("tx_data",  32'(tx_data),   32'(m_txd));
    check_eq("rx_ready", 32'(rx_ready),  (m_q.size() < DEPTH) ? 32'd1 : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic bus_read(input logic [31:0] a);
    addr = a;
    re   = 1'b1;
    cycle();
    re   = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    cycle();
    we    = 1'b0;
  endtask

  logic [7:0]  got[$];
  logic [31:0] addr_pool[8];
  int          k;

  initial begin
    addr_pool[0] = BASE;
    addr_pool[1] = BASE + 32'h4;
    addr_pool[2] = BASE + 32'h8;
    addr_pool[3] = BASE + 32'h10;
    addr_pool[4] = BASE + 32'h18;
    addr_pool[5] = BASE + 32'hC;
    addr_pool[6] = BASE + 32'h1;
    addr_pool[7] = BASE - 32'h4;

    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_eq("rst_rdata",    rdata,         32'd0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data",  32'(tx_data),  32'd0);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);

    bus_read(BASE);
    check_eq("status_after_reset", rdata, 32'h1);

    tx_ready = 1'b0;
    bus_write(BASE + 32'h8, 32'h7A);
    check_eq("tx_valid_set", 32'(tx_valid), 32'd1);
    check_eq("tx_data_7a",   32'(tx_data),  32'h7A);
    bus_write(BASE + 32'h8, 32'h55);
    check_eq("tx_drop_55",   32'(tx_data),  32'h7A);
    tx_ready = 1'b1;
    cycle();
    check_eq("tx_handshake", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    cycle();
    check_eq("tx_no_55",     32'(tx_valid), 32'd0);

    rx_valid = 1'b1;
    rx_data = 8'h11; cycle();
    rx_data = 8'h22; cycle();
    rx_data = 8'h33; cycle();
    rx_valid = 1'b0;
    bus_read(BASE);
    check_eq("status_3", rdata, 32'h3);
    bus_read(BASE + 32'h4); check_eq("rx_11", rdata, 32'h11);
    bus_read(BASE + 32'h4); check_eq("rx_22", rdata, 32'h22);
    bus_read(BASE + 32'h4); check_eq("rx_33", rdata, 32'h33);
    bus_read(BASE + 32'h4); check_eq("rx_empty_read", rdata, 32'h0);
    bus_read(BASE);
    check_eq("status_rx_empty", rdata & 32'h2, 32'h0);

    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'hA0 + 8'(i);
      cycle();
    end
    check_eq("full_rx_ready", 32'(rx_ready), 32'd0);
    rx_data = 8'hA8;
    cycle();
    rx_valid = 1'b0;
    bus_read(BASE);
    check_eq("status_ovf", rdata, 32'h7);
    bus_read(BASE);
    check_eq("status_ovf_clr", rdata, 32'h3);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(BASE + 32'h4);
      check_eq("drain", rdata, 32'hA0 + 32'(i));
    end
    bus_read(BASE + 32'h4);
    check_eq("ninth_lost", rdata, 32'h0);

    k = 0;
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'h40 + 8'(k);
      cycle();
      if (m_push) k++;
    end
    got.delete();
    addr = BASE + 32'h4;
    for (int c = 0; c < 200 && (k < 20 || m_q.size() > 0); c++) begin
      rx_valid = (k < 20);
      rx_data  = 8'h40 + 8'(k);
      re       = c[0];
      cycle();
      if (m_pop)  got.push_back(rdata[7:0]);
      if (m_push) k++;
    end
    re = 1'b0;
    rx_valid = 1'b0;
    check_eq("stream_len", 32'(got.size()), 32'd20);
    for (int i = 0; i < got.size(); i++)
      check_eq("stream_order", 32'(got[i]), 32'h40 + 32'(i));
    bus_read(BASE);

    bus_write(BASE + 32'h18, 32'h0);
    repeat (10) cycle();
    bus_read(BASE + 32'h10);
`ifdef UART_MMIO_CYCLE_COUNTER_EN
    check_eq("cycles_10", rdata, 32'd10);
`else
    check_eq("cycles_absent", rdata, 32'd0);
`endif

    rx_valid = 1'b1;
    rx_data = 8'h5A; cycle();
    rx_data = 8'h5B; cycle();
    rx_valid = 1'b0;
    bus_write(BASE + 32'h8, 32'hC3);
    bus_read(BASE);
    #3 rst = 1'b1;
    #1;
    check_eq("async_rst_rdata",    rdata,         32'd0);
    check_eq("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("async_rst_rx_ready", 32'(rx_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    bus_read(BASE);
    check_eq("post_rst_status", rdata, 32'h1);
    bus_read(BASE + 32'h4);
    check_eq("post_rst_rx", rdata, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      addr     = addr_pool[$urandom_range(7, 0)];
      re       = ($urandom_range(2, 0) == 0);
      we       = ($urandom_range(3, 0) == 0);
      wdata    = $urandom;
      rx_valid = $urandom_range(1, 0) == 1;
      rx_data  = 8'($urandom);
      tx_ready = $urandom_range(2, 0) == 0;
      cycle();
    end
    re = 1'b0;
    we = 1'b0;
    rx_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
